can_tx_scheduler: RTL
=====================

Name: can_tx_scheduler

Overview:
- Selects which of NBUF CPU transmit buffers is sent next, using the CAN arbitration order: the frame that would win on the bus goes first.
- Drives the identifier/extended/remote/datalen/activ inputs of the frame-encapsulation unit and holds them stable for a whole transmission.
- Reacts to LLC completion, arbitration-loss and error events: acknowledges the buffer on success, re-arbitrates on loss or error.
- Sits between the IOCPU transmit registers and the encapsulation/LLC transmit path.

Parameters:
- NBUF, 4, number of transmit buffers (2..8).
- MAX_RETRY, 16, error-retry limit per frame; used only with CAN_TX_RETRY_LIMIT_EN.

Ports:
- clock  in  1  main clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NBUF  buffer i holds a pending frame (level).
- id_all  in  29*NBUF  identifiers; buffer i at [29*i+28 : 29*i].
- ext_all  in  NBUF  extended-frame flags.
- rtr_all  in  NBUF  remote-frame flags.
- dlc_all  in  4*NBUF  DLCs; buffer i at [4*i+3 : 4*i].
- llc_ready  in  1  LLC is idle and may start a frame.
- tx_done  in  1  one-cycle pulse: frame transmitted successfully.
- arb_lost  in  1  one-cycle pulse: arbitration lost.
- tx_error  in  1  one-cycle pulse: error frame during transmission.
- identifier  out  29  to encapsulation.
- extended  out  1  to encapsulation.
- remote  out  1  to encapsulation.
- datalen  out  4  to encapsulation.
- activ  out  1  transmit request to encapsulation/LLC.
- grant  out  NBUF  one-hot index of the buffer being serviced.
- ack  out  NBUF  one-cycle pulse per buffer on successful transmission.
- fail  out  NBUF  one-cycle pulse per buffer when retries are exhausted.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; latched index 0; retry count 0. Reset asserted mid-transmission drops activ immediately.
- Priority key (32 bit) per buffer:
  - Standard frame: {id[28:18], rtr, 1'b0, 19'b0}.
  - Extended frame: {id[28:18], 1'b1, 1'b1, id[17:0], rtr}.
  - The numerically lowest key wins. Equal keys: the lowest buffer index wins. Only buffers with req=1 compete.
- FSM states: IDLE, SELECT, ACTIVE.
  - IDLE: activ=0. If (|req) and llc_ready, go to SELECT.
  - SELECT: one cycle. Latch the winner index; load identifier/extended/remote/datalen from that buffer; set grant. If req has meanwhile dropped to 0, return to IDLE with outputs unchanged and grant=0. Otherwise go to ACTIVE.
  - ACTIVE: activ=1; identifier/extended/remote/datalen held constant.
    - tx_done: ack[idx] pulses one cycle; retry count cleared; go to IDLE.
    - arb_lost: go to IDLE (re-arbitrate); retry count unchanged.
    - tx_error: retry count +1; go to IDLE.
- activ behaviour:
  - activ rises two cycles after a qualifying IDLE cycle.
  - After any ACTIVE exit, activ is 0 for at least one cycle. The encapsulation unit latches DLC on an activ rising edge and must see a fresh edge.
- Frame data remains on the data outputs after returning to IDLE. grant clears to 0 on ACTIVE exit.
- Simultaneous events in the same cycle: tx_done beats tx_error, which beats arb_lost.
- Event pulses outside ACTIVE are ignored.
- A req drop for the granted buffer during ACTIVE is ignored; the frame runs to an event. The CPU must not clear req mid-frame.
- Retry count is owned by the latched frame. It clears when a different index wins SELECT.
- llc_ready is sampled only in IDLE.

Optional Feature:
- Macro: CAN_TX_RETRY_LIMIT_EN.
- Defined: a tx_error that brings retry count to MAX_RETRY pulses fail[idx] (not ack), clears the count, and returns to IDLE. The CPU must clear req[idx]. The count saturates at 8-bit width.
- Undefined: unlimited retries; fail is tied to 0; no retry counter is synthesised.

Decomposition:
- Shared package/include can_tx_pkg: state encodings (IDLE=2'd0, SELECT=2'd1, ACTIVE=2'd2), KEY_W=32, ID_W=29, DLC_W=4, and a key-build function.
- One sub-module, can_prio_select: combinational min-key tree over NBUF keys with a req mask. Outputs winner index and valid. Ties resolve to the lower index.

Test Plan:
- Single request: NBUF=4, req=4'b0100, buf2 std id[28:18]=0x123, dlc=8, llc_ready=1 → activ high 2 cycles later; identifier[28:18]=0x123; datalen=8; grant=4'b0100; tx_done → ack=4'b0100 for one cycle; activ low next cycle.
- Priority: buf0 std 0x200, buf3 std 0x100, both req → buf3 first. After ack and req3 cleared, activ low ≥1 cycle, then buf0 served.
- Ties and frame type:
  - Std 0x100 data vs std 0x100 RTR → data wins.
  - Std 0x100 vs ext with base 0x100 → std wins.
  - Identical keys in buf1/buf2 → buf1 wins.
- Arbitration loss: arb_lost in ACTIVE → activ drops; re-arbitration picks a newly raised higher-priority buf0; ack never pulses for the lost attempt.
- Simultaneous tx_done+tx_error → ack pulse, no retry increment. With CAN_TX_RETRY_LIMIT_EN and MAX_RETRY=3, three tx_error → fail pulses on the third, no ack.
- Asynchronous reset asserted mid-ACTIVE → activ, grant and busy go 0 without a clock edge. After release, a pending req is re-served from SELECT.

Source files
------------

// File: rtl/can_tx_pkg.sv
// can_tx_pkg: shared definitions for the CAN transmit scheduler.
//   state_t   : scheduler FSM states (IDLE, SELECT, ACTIVE)
//   KEY_W     : width of the arbitration priority key
//   ID_W      : identifier width
//   DLC_W     : data length code width
//   build_key : maps (id, ext, rtr) to a key whose numeric order equals CAN bus
//               arbitration order (lower key wins on the bus)
package can_tx_pkg;

  localparam int unsigned KEY_W = 32;
  localparam int unsigned ID_W  = 29;
  localparam int unsigned DLC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Bit positions follow the on-wire field order. A standard frame puts RTR
  // right after the base ID and a dominant IDE bit after it. An extended
  // frame sends a recessive SRR and a recessive IDE in those two positions.
  // As a result a standard data frame beats an extended frame with the same
  // base ID.
  function automatic logic [KEY_W-1:0] build_key(
    input logic [ID_W-1:0] id,
    input logic            ext,
    input logic            rtr
  );
    if (ext) begin
      return {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
    end
    return {id[28:18], rtr, 1'b0, 19'b0};
  endfunction

endpackage

// File: rtl/can_prio_select.sv
// can_prio_select: combinational minimum-key search across the transmit buffers.
//   keys  in  NBUF*KEY_W  priority key for each buffer; buffer i is at [KEY_W*i +: KEY_W]
//   mask  in  NBUF        only buffers whose mask bit is set take part
//   idx   out             index of the lowest key; on equal keys the lower index wins
//   valid out             at least one buffer took part
module can_prio_select
  import can_tx_pkg::*;
#(
  parameter int unsigned NBUF = 4
) (
  input  logic [NBUF*KEY_W-1:0]     keys,
  input  logic [NBUF-1:0]           mask,
  output logic [$clog2(NBUF)-1:0]   idx,
  output logic                      valid
);

  localparam int unsigned IDX_W = $clog2(NBUF);

  logic [KEY_W-1:0] best_key;

  // Buffers are scanned in ascending index order and a buffer is taken only
  // when its key is strictly lower, so on equal keys the earlier index stays.
  always_comb begin
    best_key = '1;
    idx      = '0;
    valid    = 1'b0;
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (mask[i] && (!valid || (keys[KEY_W*i +: KEY_W] < best_key))) begin
        best_key = keys[KEY_W*i +: KEY_W];
        idx      = IDX_W'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: chooses the next CPU transmit buffer in CAN arbitration
// order and presents that frame to the encapsulation/LLC transmit path.
// Optional feature: define CAN_TX_RETRY_LIMIT_EN to give up on a frame after
// MAX_RETRY error frames. The failure is reported on fail[]. Without the
// macro, retries are unlimited and fail[] is tied to 0.
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   req                          pending-frame level for each buffer
//   id_all/ext_all/rtr_all/dlc_all  frame fields packed per buffer
//   llc_ready                    LLC idle; sampled only in IDLE
//   tx_done/arb_lost/tx_error    LLC event pulses, honoured only in ACTIVE
//   identifier/extended/remote/datalen/activ  frame to the encapsulation unit
//   grant                        one-hot index of the buffer being serviced
//   ack/fail                     per-buffer completion pulses
//   busy                         scheduler is not idle
module can_tx_scheduler
  import can_tx_pkg::*;
#(
  parameter int unsigned NBUF      = 4,
  parameter int unsigned MAX_RETRY = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NBUF-1:0]       req,
  input  logic [29*NBUF-1:0]    id_all,
  input  logic [NBUF-1:0]       ext_all,
  input  logic [NBUF-1:0]       rtr_all,
  input  logic [4*NBUF-1:0]     dlc_all,
  input  logic                  llc_ready,
  input  logic                  tx_done,
  input  logic                  arb_lost,
  input  logic                  tx_error,
  output logic [28:0]           identifier,
  output logic                  extended,
  output logic                  remote,
  output logic [3:0]            datalen,
  output logic                  activ,
  output logic [NBUF-1:0]       grant,
  output logic [NBUF-1:0]       ack,
  output logic [NBUF-1:0]       fail,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(NBUF);

  if ((NBUF < 2) || (NBUF > 8)) begin : g_nbuf_range
    $error("can_tx_scheduler: NBUF must be in 2..8");
  end
  if ((MAX_RETRY < 1) || (MAX_RETRY > 255)) begin : g_retry_range
    $error("can_tx_scheduler: MAX_RETRY must be in 1..255");
  end

  logic [NBUF*KEY_W-1:0] keys;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_valid;
  logic [NBUF-1:0]       win_onehot;

  state_t                state;
  logic [IDX_W-1:0]      idx;

  for (genvar g = 0; g < NBUF; g++) begin : g_keys
    assign keys[KEY_W*g +: KEY_W] = build_key(id_all[ID_W*g +: ID_W], ext_all[g], rtr_all[g]);
  end

  can_prio_select #(
    .NBUF (NBUF)
  ) u_prio_select (
    .keys  (keys),
    .mask  (req),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

`ifdef CAN_TX_RETRY_LIMIT_EN
  logic [7:0] retry_cnt;
`else
  assign fail = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      identifier <= '0;
      extended   <= 1'b0;
      remote     <= 1'b0;
      datalen    <= '0;
      activ      <= 1'b0;
      grant      <= '0;
      ack        <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
      fail       <= '0;
      retry_cnt  <= '0;
`endif
    end else begin
      ack <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
      fail <= '0;
`endif
      case (state)
        IDLE: begin
          if ((|req) && llc_ready) begin
            state <= SELECT;
          end
        end

        SELECT: begin
          if (win_valid) begin
            idx        <= win_idx;
            identifier <= id_all[ID_W*win_idx +: ID_W];
            extended   <= ext_all[win_idx];
            remote     <= rtr_all[win_idx];
            datalen    <= dlc_all[DLC_W*win_idx +: DLC_W];
            grant      <= win_onehot;
            activ      <= 1'b1;
            state      <= ACTIVE;
`ifdef CAN_TX_RETRY_LIMIT_EN
            // The error count belongs to the frame; a new winner starts fresh.
            if (win_idx != idx) begin
              retry_cnt <= '0;
            end
`endif
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end

        ACTIVE: begin
          // Priority order: done, then error, then arbitration loss.
          if (tx_done) begin
            ack[idx] <= 1'b1;
            activ    <= 1'b0;
            grant    <= '0;
            state    <= IDLE;
`ifdef CAN_TX_RETRY_LIMIT_EN
            retry_cnt <= '0;
`endif
          end else if (tx_error) begin
            activ <= 1'b0;
            grant <= '0;
            state <= IDLE;
`ifdef CAN_TX_RETRY_LIMIT_EN
            if (({24'd0, retry_cnt} + 32'd1) >= MAX_RETRY) begin
              fail[idx] <= 1'b1;
              retry_cnt <= '0;
            end else if (retry_cnt != '1) begin
              retry_cnt <= retry_cnt + 8'd1;
            end
`endif
          end else if (arb_lost) begin
            activ <= 1'b0;
            grant <= '0;
            state <= IDLE;
          end
        end

        default: begin
          activ <= 1'b0;
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
